mem_arbiter: RTL

Shares one single-ported synchronous memory between the instruction-fetch path (pc_reg/if_id) and the load/store path (mem stage) of the five-stage core. A three-state FSM grants one requester at a time and drives a registered memory request. It then returns read data with a one-cycle acknowledge. While a request is pending it raises per-stage stall requests toward the pipeline controller.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_arb_prio.sv | 30 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the instruction/data memory arbiter:
//   bus width constants, FSM state encoding, and requester IDs.
package mem_arbiter_pkg;

  localparam int unsigned AddressBus  = 32;
  localparam int unsigned RegisterBus = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_INST = 1'b0,
    ARB_DATA = 1'b1
  } arb_id_e;

  function automatic arb_id_e arb_other(input arb_id_e id);
    return (id == ARB_DATA) ? ARB_INST : ARB_DATA;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// arb_prio
//   Combinational two-way grant between the (already masked) fetch and
//   data requests. When both are present, prio_i names the winner.
//   Ports:
//     inst_req_i  masked instruction-fetch request
//     data_req_i  masked data request
//     prio_i      requester favoured under contention
//     inst_gnt_o  grant to instruction fetch
//     data_gnt_o  grant to data path (one-hot with inst_gnt_o)
module arb_prio
  import mem_arbiter_pkg::*;
(
  input  logic    inst_req_i,
  input  logic    data_req_i,
  input  arb_id_e prio_i,
  output logic    inst_gnt_o,
  output logic    data_gnt_o
);

  always_comb begin
    inst_gnt_o = 1'b0;
    data_gnt_o = 1'b0;
    if (data_req_i && (!inst_req_i || prio_i == ARB_DATA)) begin
      data_gnt_o = 1'b1;
    end else if (inst_req_i) begin
      inst_gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported synchronous memory between instruction fetch
//   and the load/store stage. A three-state FSM grants one requester,
//   drives a registered memory request, and returns registered read data
//   with a one-cycle ack. Stall requests are combinational from req/ack.
//
//   Build option: define MEM_ARB_ROUND_ROBIN_EN for alternating service
//   under contention; otherwise fixed priority, data over instruction.
//
//   Ports:
//     clock, reset                 rising-edge clock, sync active-high reset
//     i_req/i_addr -> i_ack/i_rdata       fetch request / completion
//     d_req/d_we/d_sel/d_addr/d_wdata -> d_ack/d_rdata   data request
//     mem_ce/mem_we/mem_sel/mem_addr/mem_wdata -> memory request
//     mem_rdata/mem_ready          memory response
//     stall_req_if/stall_req_mem   pipeline stall requests
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddressBus,
  parameter int unsigned DATA_W = RegisterBus
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_sel,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall_req_if,
  output logic                stall_req_mem
);

  arb_state_e          state_q;
  logic                mem_ce_q;
  logic                mem_we_q;
  logic [DATA_W/8-1:0] mem_sel_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                i_ack_q;
  logic                d_ack_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  // A requester's req is still high during its own ack cycle; masking it
  // there prevents the completed access from being granted a second time.
  logic    i_req_m;
  logic    d_req_m;
  logic    gnt_i;
  logic    gnt_d;
  arb_id_e prio;

  assign i_req_m = i_req & ~i_ack_q;
  assign d_req_m = d_req & ~d_ack_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_id_e prio_q;
  assign prio = prio_q;
`else
  assign prio = ARB_DATA;
`endif

  arb_prio u_arb_prio (
    .inst_req_i (i_req_m),
    .data_req_i (d_req_m),
    .prio_i     (prio),
    .inst_gnt_o (gnt_i),
    .data_gnt_o (gnt_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_q      <= ARB_DATA;
`endif
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_d) begin
            mem_ce_q    <= 1'b1;
            mem_we_q    <= d_we;
            mem_sel_q   <= d_sel;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            state_q     <= BUSY_D;
          end else if (gnt_i) begin
            mem_ce_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= '1;
            mem_addr_q  <= i_addr;
            state_q     <= BUSY_I;
          end else begin
            mem_ce_q    <= 1'b0;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          // Only a grant won in contention moves the pointer.
          if (i_req_m && d_req_m) begin
            prio_q <= arb_other(gnt_d ? ARB_DATA : ARB_INST);
          end
`endif
        end
        BUSY_I: begin
          if (mem_ready) begin
            i_rdata_q <= mem_rdata;
            i_ack_q   <= 1'b1;
            mem_ce_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            d_rdata_q <= mem_rdata;
            d_ack_q   <= 1'b1;
            mem_ce_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          mem_ce_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign mem_ce        = mem_ce_q;
  assign mem_we        = mem_we_q;
  assign mem_sel       = mem_sel_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign i_ack         = i_ack_q;
  assign d_ack         = d_ack_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign stall_req_if  = i_req & ~i_ack_q;
  assign stall_req_mem = d_req & ~d_ack_q;

endmodule
